// File: rtl/tap_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tap_window_feeder
// Purpose  : Initiator side of a 4-tap multiply-add datapath. Accepts a
//            scalar sample stream (valid/ready) with a per-sample mu tag.
//            It keeps a 4-deep tap delay line and issues one registered
//            4-tap window, with its mu tag and an enable strobe, for every
//            accepted sample. On end-of-stream it shifts in three zeros so
//            the downstream stage sees the full convolution tail.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active low
//            sample_in    - signed input sample
//            mu_in        - tag accompanying sample_in
//            sample_valid - sample_in/mu_in/sample_last valid
//            sample_last  - final sample of a stream
//            sample_ready - feeder accepts this cycle (state only)
//            data1..4_out - taps x[n] (newest) .. x[n-3] (oldest)
//            mu_out       - tag of the current window
//            enable_out   - one-cycle strobe, window valid
//            busy         - state is not IDLE
//            window_cnt   - windows issued since reset, wraps
// Revision : 1.0 - initial release
// ============================================================================
module tap_window_feeder #(
  parameter int DATA_W = 16,
  parameter int MU_W   = 16,
  parameter int PRIME  = 0,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic        [MU_W-1:0]   mu_in,
  input  logic                     sample_valid,
  input  logic                     sample_last,
  output logic                     sample_ready,
  output logic signed [DATA_W-1:0] data1_out,
  output logic signed [DATA_W-1:0] data2_out,
  output logic signed [DATA_W-1:0] data3_out,
  output logic signed [DATA_W-1:0] data4_out,
  output logic        [MU_W-1:0]   mu_out,
  output logic                     enable_out,
  output logic                     busy,
  output logic        [CNT_W-1:0]  window_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                     state_q,  state_d;
  logic        [1:0]          fill_cnt_q, fill_cnt_d;
  logic        [1:0]          drain_cnt_q, drain_cnt_d;
  logic signed [DATA_W-1:0]   tap1_q, tap1_d;
  logic signed [DATA_W-1:0]   tap2_q, tap2_d;
  logic signed [DATA_W-1:0]   tap3_q, tap3_d;
  logic signed [DATA_W-1:0]   tap4_q, tap4_d;
  logic        [MU_W-1:0]     mu_q, mu_d;
  logic                       en_q, en_d;
  logic        [CNT_W-1:0]    cnt_q, cnt_d;

  logic                       accept;
  logic                       do_shift;
  logic signed [DATA_W-1:0]   shift_val;

  // Ready depends on state only, so no combinational path from valid.
  assign sample_ready = (state_q != S_DRAIN);
  assign accept       = sample_valid & sample_ready;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mu_d        = mu_q;
    en_d        = 1'b0;
    do_shift    = 1'b0;
    shift_val   = sample_in;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          do_shift = 1'b1;
          mu_d     = mu_in;
          if (sample_last) begin
            // Single-sample stream: issue it and go straight to the tail.
            en_d       = 1'b1;
            fill_cnt_d = 2'd0;
            state_d    = S_DRAIN;
          end else if (PRIME != 0) begin
            fill_cnt_d = 2'd1;
            state_d    = S_FILL;
          end else begin
            en_d    = 1'b1;
            state_d = S_RUN;
          end
        end
      end

      S_FILL: begin
        if (accept) begin
          do_shift = 1'b1;
          mu_d     = mu_in;
          if (sample_last) begin
            // A short stream still gets its partial window issued.
            en_d       = 1'b1;
            fill_cnt_d = 2'd0;
            state_d    = S_DRAIN;
          end else if (fill_cnt_q == 2'd3) begin
            en_d       = 1'b1;
            fill_cnt_d = 2'd0;
            state_d    = S_RUN;
          end else begin
            fill_cnt_d = fill_cnt_q + 2'd1;
          end
        end
      end

      S_RUN: begin
        if (accept) begin
          do_shift = 1'b1;
          mu_d     = mu_in;
          en_d     = 1'b1;
          if (sample_last) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Zero injection; mu_out keeps the last accepted tag.
        do_shift  = 1'b1;
        shift_val = '0;
        en_d      = 1'b1;
        if (drain_cnt_q == 2'd2) begin
          drain_cnt_d = 2'd0;
          fill_cnt_d  = 2'd0;
          state_d     = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_shift) begin
      tap1_d = shift_val;
      tap2_d = tap1_q;
      tap3_d = tap2_q;
      tap4_d = tap3_q;
    end else if (state_q == S_IDLE) begin
      // The last drain window is shown for one cycle in IDLE, then cleared.
      tap1_d = '0;
      tap2_d = '0;
      tap3_d = '0;
      tap4_d = '0;
    end else begin
      tap1_d = tap1_q;
      tap2_d = tap2_q;
      tap3_d = tap3_q;
      tap4_d = tap4_q;
    end

    cnt_d = en_d ? (cnt_q + CNT_W'(1)) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      fill_cnt_q  <= 2'd0;
      drain_cnt_q <= 2'd0;
      tap1_q      <= '0;
      tap2_q      <= '0;
      tap3_q      <= '0;
      tap4_q      <= '0;
      mu_q        <= '0;
      en_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      tap1_q      <= tap1_d;
      tap2_q      <= tap2_d;
      tap3_q      <= tap3_d;
      tap4_q      <= tap4_d;
      mu_q        <= mu_d;
      en_q        <= en_d;
      cnt_q       <= cnt_d;
    end
  end

  assign data1_out  = tap1_q;
  assign data2_out  = tap2_q;
  assign data3_out  = tap3_q;
  assign data4_out  = tap4_q;
  assign mu_out     = mu_q;
  assign enable_out = en_q;
  assign busy       = (state_q != S_IDLE);
  assign window_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_window_feeder
// Purpose  : Directed self-checking bench for tap_window_feeder. Three
//            instances: PRIME=0, PRIME=1 and PRIME=0 with a 4-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tap_window_feeder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: PRIME=0
  logic [15:0] s0, mu0, d01, d02, d03, d04, m0, c0;
  logic        v0, l0, r0, e0, b0;
  // Instance 1: PRIME=1
  logic [15:0] s1, mu1, d11, d12, d13, d14, m1, c1;
  logic        v1, l1, r1, e1, b1;
  // Instance 2: PRIME=0, CNT_W=4
  logic [15:0] s2, mu2, d21, d22, d23, d24, m2;
  logic [3:0]  c2;
  logic        v2, l2, r2, e2, b2;

  tap_window_feeder #(.DATA_W(16), .MU_W(16), .PRIME(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .sample_in(s0), .mu_in(mu0), .sample_valid(v0),
    .sample_last(l0), .sample_ready(r0), .data1_out(d01), .data2_out(d02),
    .data3_out(d03), .data4_out(d04), .mu_out(m0), .enable_out(e0),
    .busy(b0), .window_cnt(c0));

  tap_window_feeder #(.DATA_W(16), .MU_W(16), .PRIME(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .sample_in(s1), .mu_in(mu1), .sample_valid(v1),
    .sample_last(l1), .sample_ready(r1), .data1_out(d11), .data2_out(d12),
    .data3_out(d13), .data4_out(d14), .mu_out(m1), .enable_out(e1),
    .busy(b1), .window_cnt(c1));

  tap_window_feeder #(.DATA_W(16), .MU_W(16), .PRIME(0), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .sample_in(s2), .mu_in(mu2), .sample_valid(v2),
    .sample_last(l2), .sample_ready(r2), .data1_out(d21), .data2_out(d22),
    .data3_out(d23), .data4_out(d24), .mu_out(m2), .enable_out(e2),
    .busy(b2), .window_cnt(c2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window check for instance 0: taps packed newest..oldest, enable, count.
  task automatic win0(input string tag, input logic [63:0] taps,
                      input logic en, input logic [15:0] cnt);
    chk({tag, "_taps"}, {d01, d02, d03, d04}, taps);
    chk({tag, "_en"},   {63'd0, e0}, {63'd0, en});
    chk({tag, "_cnt"},  {48'd0, c0}, {48'd0, cnt});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    s0 = '0; mu0 = '0; v0 = 1'b0; l0 = 1'b0;
    s1 = '0; mu1 = '0; v1 = 1'b0; l1 = 1'b0;
    s2 = '0; mu2 = '0; v2 = 1'b0; l2 = 1'b0;

    // ---------------- Reset, PRIME=0 ----------------
    #1;
    win0("rst_init", 64'h0, 1'b0, 16'd0);
    chk("rst_init_ready", {63'd0, r0}, 64'd1);
    chk("rst_init_busy",  {63'd0, b0}, 64'd0);
    chk("rst_init_mu",    {48'd0, m0}, 64'd0);
    #11;
    rst = 1'b1;
    v0 = 1'b1; s0 = 16'h0100; mu0 = 16'h0007;
    tick();
    win0("first", 64'h0100_0000_0000_0000, 1'b1, 16'd1);
    chk("first_mu",   {48'd0, m0}, 64'h7);
    chk("first_busy", {63'd0, b0}, 64'd1);
    v0 = 1'b0;
    tick();
    win0("idle_hold", 64'h0100_0000_0000_0000, 1'b0, 16'd1);

    // Asynchronous reset in the middle of a cycle
    #2 rst = 1'b0;
    #1;
    win0("async_rst", 64'h0, 1'b0, 16'd0);
    chk("async_rst_mu",    {48'd0, m0}, 64'd0);
    chk("async_rst_busy",  {63'd0, b0}, 64'd0);
    chk("async_rst_ready", {63'd0, r0}, 64'd1);
    #2 rst = 1'b1;

    // ---------------- Drain, PRIME=0 ----------------
    v0 = 1'b1; s0 = 16'd10; l0 = 1'b0; mu0 = 16'h0011;
    tick();
    win0("drn_w1", {16'd10, 16'd0, 16'd0, 16'd0}, 1'b1, 16'd1);
    s0 = 16'd20; l0 = 1'b1; mu0 = 16'h0022;
    tick();
    win0("drn_w2", {16'd20, 16'd10, 16'd0, 16'd0}, 1'b1, 16'd2);
    chk("drn_ready1", {63'd0, r0}, 64'd0);
    chk("drn_busy1",  {63'd0, b0}, 64'd1);
    s0 = 16'd99; l0 = 1'b0; mu0 = 16'h0033;
    tick();
    win0("drn_w3", {16'd0, 16'd20, 16'd10, 16'd0}, 1'b1, 16'd3);
    chk("drn_ready2", {63'd0, r0}, 64'd0);
    chk("drn_mu",     {48'd0, m0}, 64'h22);
    tick();
    win0("drn_w4", {16'd0, 16'd0, 16'd20, 16'd10}, 1'b1, 16'd4);
    chk("drn_ready3", {63'd0, r0}, 64'd0);
    v0 = 1'b0;
    tick();
    win0("drn_w5", {16'd0, 16'd0, 16'd0, 16'd20}, 1'b1, 16'd5);
    chk("drn_busy_end",  {63'd0, b0}, 64'd0);
    chk("drn_ready_end", {63'd0, r0}, 64'd1);
    tick();
    win0("drn_clear", 64'h0, 1'b0, 16'd5);

    // ---------------- Backpressure gaps ----------------
    v0 = 1'b1; s0 = 16'h7FFF; mu0 = 16'h0044;
    tick();
    win0("bp_w1", 64'h7FFF_0000_0000_0000, 1'b1, 16'd6);
    v0 = 1'b0; s0 = 16'h1234;
    tick();
    win0("bp_gap1", 64'h7FFF_0000_0000_0000, 1'b0, 16'd6);
    tick();
    win0("bp_gap2", 64'h7FFF_0000_0000_0000, 1'b0, 16'd6);
    v0 = 1'b1; s0 = 16'h8000; mu0 = 16'h0055;
    tick();
    win0("bp_w2", 64'h8000_7FFF_0000_0000, 1'b1, 16'd7);
    chk("bp_mu", {48'd0, m0}, 64'h55);

    // ---------------- Reset mid-drain ----------------
    s0 = 16'h0055; l0 = 1'b1;
    tick();
    win0("rmd_last", 64'h0055_8000_7FFF_0000, 1'b1, 16'd8);
    v0 = 1'b0; l0 = 1'b0;
    tick();
    win0("rmd_drain1", 64'h0000_0055_8000_7FFF, 1'b1, 16'd9);
    #2 rst = 1'b0;
    #1;
    win0("rmd_rst", 64'h0, 1'b0, 16'd0);
    chk("rmd_rst_busy", {63'd0, b0}, 64'd0);
    #2 rst = 1'b1;
    chk("rmd_ready", {63'd0, r0}, 64'd1);
    v0 = 1'b1; s0 = 16'h0033;
    tick();
    win0("rmd_next", 64'h0033_0000_0000_0000, 1'b1, 16'd1);
    v0 = 1'b0;

    // ---------------- Fill suppression, PRIME=1 ----------------
    v1 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      s1 = 16'(i);
      mu1 = 16'(i + 16'h0100);
      tick();
      if (i <= 3) begin
        chk($sformatf("fill_en_%0d", i), {63'd0, e1}, 64'd0);
        chk($sformatf("fill_busy_%0d", i), {63'd0, b1}, 64'd1);
      end
    end
    v1 = 1'b0;
    chk("fill_w5_taps", {d11, d12, d13, d14}, {16'd5, 16'd4, 16'd3, 16'd2});
    chk("fill_w5_en",   {63'd0, e1}, 64'd1);
    chk("fill_w5_cnt",  {48'd0, c1}, 64'd2);
    chk("fill_w5_mu",   {48'd0, m1}, 64'h0105);
    tick();
    chk("fill_after_en", {63'd0, e1}, 64'd0);

    // ---------------- Counter wrap, CNT_W=4 ----------------
    v2 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      s2 = 16'(i * 3);
      tick();
      chk($sformatf("wrap_cnt_%0d", i), {60'd0, c2}, 64'(i % 16));
      chk($sformatf("wrap_d1_%0d", i),  {48'd0, d21}, 64'(i * 3));
    end
    v2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // The directed sequence is finite; this only guards against a stalled clock.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
